// File: rtl/rv_pkg.sv
// Shared RISC-V integer pipeline definitions: data width, load-select
// encodings (funct3) and the hard-wired zero register index.
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] LS_LB  = 3'b000;
   localparam logic [2:0] LS_LH  = 3'b001;
   localparam logic [2:0] LS_LW  = 3'b010;
   localparam logic [2:0] LS_LBU = 3'b100;
   localparam logic [2:0] LS_LHU = 3'b101;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_extend.sv
// Load formatter: picks the byte/halfword addressed by the low address bits
// out of a word-aligned memory read and sign- or zero-extends it.
module load_extend
   import rv_pkg::*;
(
   input  logic [XLEN-1:0] wb_datamem,
   input  logic [1:0]      offset,
   input  logic [2:0]      wb_Load_sel,
   output logic [XLEN-1:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = wb_datamem[7:0];
      case (offset)
         2'd0: byte_sel = wb_datamem[7:0];
         2'd1: byte_sel = wb_datamem[15:8];
         2'd2: byte_sel = wb_datamem[23:16];
         2'd3: byte_sel = wb_datamem[31:24];
         default: byte_sel = wb_datamem[7:0];
      endcase
      // Halfword loads ignore offset[0]; misalignment is not trapped here.
      half_sel = offset[1] ? wb_datamem[31:16] : wb_datamem[15:0];
   end

   always_comb begin
      load_data = wb_datamem;
      case (wb_Load_sel)
         LS_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LS_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
         LS_LW:   load_data = wb_datamem;
         LS_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
         LS_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
         default: load_data = wb_datamem;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and integer register file with two decode-stage read
// ports that bypass the value being written in the same cycle.
module wb_regfile
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] wb_dataALU,
   input  logic [XLEN-1:0] wb_datamem,
   input  logic            wb_memtoreg,
   input  logic            wb_RegWr,
   input  logic            wb_MemRd,
   input  logic [2:0]      wb_Load_sel,
   input  logic [4:0]      wb_rd,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_we
);

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] load_data;

   load_extend u_load_extend (
      .wb_datamem  (wb_datamem),
      .offset      (wb_dataALU[1:0]),
      .wb_Load_sel (wb_Load_sel),
      .load_data   (load_data)
   );

   // Non-load memtoreg passes the raw memory word straight through.
   always_comb begin
      wb_data = wb_dataALU;
      if (wb_memtoreg)
         wb_data = wb_MemRd ? load_data : wb_datamem;
   end

   assign wb_we = wb_RegWr && (wb_rd != REG_ZERO) && !rst;

   // Entry 0 is cleared by reset and never selected by wb_we, so it stays 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wb_we) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // wb_we is already low during reset, which disables the bypass then.
   always_comb begin
      rs1_data = '0;
      if (rs1_addr != REG_ZERO)
         rs1_data = (wb_we && wb_rd == rs1_addr) ? wb_data : regs[rs1_addr];
   end

   always_comb begin
      rs2_data = '0;
      if (rs2_addr != REG_ZERO)
         rs2_data = (wb_we && wb_rd == rs2_addr) ? wb_data : regs[rs2_addr];
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset clear, load formatting, ALU
// writeback, same-cycle bypass, x0 protection and reset/write collision.
`timescale 1ns/1ps
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_dataALU, wb_datamem;
   logic        wb_memtoreg, wb_RegWr, wb_MemRd;
   logic [2:0]  wb_Load_sel;
   logic [4:0]  wb_rd, rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data;
   logic        wb_we;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk         (clk),
      .rst         (rst),
      .wb_dataALU  (wb_dataALU),
      .wb_datamem  (wb_datamem),
      .wb_memtoreg (wb_memtoreg),
      .wb_RegWr    (wb_RegWr),
      .wb_MemRd    (wb_MemRd),
      .wb_Load_sel (wb_Load_sel),
      .wb_rd       (wb_rd),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .wb_data     (wb_data),
      .wb_we       (wb_we)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_write(input logic we, input logic [4:0] rd, input logic [31:0] alu);
      wb_RegWr    = we;
      wb_rd       = rd;
      wb_dataALU  = alu;
      wb_memtoreg = 1'b0;
      wb_MemRd    = 1'b0;
   endtask

   task automatic set_load(input logic [2:0] sel, input logic [1:0] off);
      wb_memtoreg = 1'b1;
      wb_MemRd    = 1'b1;
      wb_Load_sel = sel;
      wb_dataALU  = {30'h0000_1000, off};
      #1;
   endtask

   initial begin
      rst = 1'b1;
      wb_datamem = 32'h0;
      wb_Load_sel = 3'b010;
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      // A write request held through reset must never strobe.
      set_write(1'b1, 5'd4, 32'h0000_0099);
      #1;
      chk("we_in_reset_0", {31'b0, wb_we}, 32'd0);
      @(posedge clk); #1;
      chk("we_in_reset_1", {31'b0, wb_we}, 32'd0);
      @(posedge clk); #1;
      chk("we_in_reset_2", {31'b0, wb_we}, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      set_write(1'b0, 5'd0, 32'h0);
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         rs1_addr = 5'(i);
         rs2_addr = 5'(32 - i);
         #1;
         chk($sformatf("rst_rs1_x%0d", i), rs1_data, 32'h0);
         chk($sformatf("rst_rs2_x%0d", 32 - i), rs2_data, 32'h0);
      end

      // Load formatting
      @(negedge clk);
      wb_datamem = 32'h80F1_7F82;
      set_load(3'b000, 2'd0); chk("lb_off0",  wb_data, 32'hFFFF_FF82);
      set_load(3'b100, 2'd0); chk("lbu_off0", wb_data, 32'h0000_0082);
      set_load(3'b000, 2'd1); chk("lb_off1",  wb_data, 32'h0000_007F);
      set_load(3'b000, 2'd3); chk("lb_off3",  wb_data, 32'hFFFF_FF80);
      set_load(3'b001, 2'd2); chk("lh_off2",  wb_data, 32'hFFFF_80F1);
      set_load(3'b001, 2'd1); chk("lh_off1",  wb_data, 32'h0000_7F82);
      set_load(3'b101, 2'd3); chk("lhu_off3", wb_data, 32'h0000_80F1);
      set_load(3'b010, 2'd0); chk("lw",       wb_data, 32'h80F1_7F82);
      set_load(3'b011, 2'd1); chk("f3_011",   wb_data, 32'h80F1_7F82);
      set_load(3'b110, 2'd2); chk("f3_110",   wb_data, 32'h80F1_7F82);
      wb_MemRd = 1'b0; wb_Load_sel = 3'b000; #1;
      chk("memtoreg_raw", wb_data, 32'h80F1_7F82);

      // ALU writeback to x5
      @(negedge clk);
      set_write(1'b1, 5'd5, 32'h1234_5678);
      #1;
      chk("alu_wb_data", wb_data, 32'h1234_5678);
      chk("alu_wb_we", {31'b0, wb_we}, 32'd1);
      @(negedge clk);
      set_write(1'b0, 5'd0, 32'h0);
      rs1_addr = 5'd5;
      #1;
      chk("alu_rd_x5", rs1_data, 32'h1234_5678);

      // Bypass: x7 holds an old value, new write visible before the edge
      @(negedge clk);
      set_write(1'b1, 5'd7, 32'h1111_1111);
      @(negedge clk);
      set_write(1'b1, 5'd7, 32'hDEAD_BEEF);
      rs1_addr = 5'd7;
      rs2_addr = 5'd7;
      #1;
      chk("byp_rs1", rs1_data, 32'hDEAD_BEEF);
      chk("byp_rs2", rs2_data, 32'hDEAD_BEEF);
      // Back-to-back write to the same rd: bypass shows the newest value
      @(negedge clk);
      set_write(1'b1, 5'd7, 32'hCAFE_F00D);
      #1;
      chk("b2b_byp", rs1_data, 32'hCAFE_F00D);
      @(negedge clk);
      set_write(1'b0, 5'd7, 32'h0);
      #1;
      chk("b2b_arr_rs1", rs1_data, 32'hCAFE_F00D);
      chk("b2b_arr_rs2", rs2_data, 32'hCAFE_F00D);

      // x0 protection
      @(negedge clk);
      set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
      rs1_addr = 5'd0;
      rs2_addr = 5'd5;
      #1;
      chk("x0_we", {31'b0, wb_we}, 32'd0);
      chk("x0_rd_during", rs1_data, 32'h0);
      chk("x0_other_reg", rs2_data, 32'h1234_5678);
      @(negedge clk);
      set_write(1'b0, 5'd0, 32'h0);
      #1;
      chk("x0_rd_after", rs1_data, 32'h0);

      // Reset colliding with a write
      @(negedge clk);
      set_write(1'b1, 5'd3, 32'h0000_0055);
      @(negedge clk);
      rst = 1'b1;
      set_write(1'b1, 5'd3, 32'h0000_00AA);
      rs1_addr = 5'd3;
      rs2_addr = 5'd7;
      #1;
      chk("coll_we", {31'b0, wb_we}, 32'd0);
      chk("coll_no_byp", rs1_data, 32'h0000_0055);
      chk("coll_wb_data", wb_data, 32'h0000_00AA);
      @(negedge clk);
      rst = 1'b0;
      set_write(1'b0, 5'd0, 32'h0);
      #1;
      chk("coll_x3_clr", rs1_data, 32'h0);
      chk("coll_x7_clr", rs2_data, 32'h0);
      set_write(1'b1, 5'd3, 32'h0000_00AA);
      @(negedge clk);
      set_write(1'b0, 5'd0, 32'h0);
      rs2_addr = 5'd3;
      #1;
      chk("post_rst_rs1", rs1_data, 32'h0000_00AA);
      chk("post_rst_rs2", rs2_data, 32'h0000_00AA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
